// File: rtl/loop_filter_pi.sv
// loop_filter_pi: parametrised PI loop filter between the phase detector and
// the NCO. Every PERIOD clocks the integrator is updated (phase A, count==1).
// The output is then formed from the new integrator plus the proportional
// term (phase B, count==2). All additions saturate at DW bits.
// Optional lock detector is compiled in when LF_LOCK_EN is defined.
module loop_filter_pi #(
  parameter int DW       = 28,
  parameter int PERIOD   = 8,
  parameter int SW       = 5,
  parameter int LOCK_THR = 2**20,
  parameter int LOCK_CNT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [DW-1:0] pd,
  input  logic [SW-1:0]        c1_shift,
  input  logic [SW-1:0]        c2_shift,
  input  logic                 freeze,
  input  logic                 clear,
  output logic signed [DW-1:0] frequency_df,
  output logic                 df_valid,
  output logic                 sat,
  output logic                 locked
);

  localparam int CW = $clog2(PERIOD);
  localparam logic signed [DW-1:0] DF_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] DF_MIN = {1'b1, {(DW-1){1'b0}}};

  // Arithmetic right shift; shifting by DW or more yields 0 even for negative x.
  function automatic logic signed [DW-1:0] shr(input logic signed [DW-1:0] x,
                                               input logic [SW-1:0] s);
    if (int'(s) >= DW) return '0;
    return x >>> s;
  endfunction

  // Saturating add at DW+1 bits; MSB of the result flags a clamp.
  function automatic logic [DW:0] sat_add(input logic signed [DW-1:0] a,
                                          input logic signed [DW-1:0] b);
    logic [DW:0] w;
    w = {a[DW-1], a} + {b[DW-1], b};
    if (w[DW] != w[DW-1]) return {1'b1, (w[DW] ? DF_MIN : DF_MAX)};
    return {1'b0, w[DW-1:0]};
  endfunction

  logic [CW-1:0]        count_q, count_d;
  logic signed [DW-1:0] sum_q, sum_d;
  logic signed [DW-1:0] df_q, df_d;
  logic                 df_valid_q, df_valid_d;
  logic                 sat_q, sat_d;
  logic                 phase_a, phase_b;
  logic [DW:0]          sum_res, df_res;

  assign phase_a = (count_q == CW'(1));
  assign phase_b = (count_q == CW'(2));
  // Phase B reads sum_q, which already holds the value written in phase A.
  assign sum_res = sat_add(sum_q, shr(pd, c2_shift));
  assign df_res  = sat_add(sum_q, shr(pd, c1_shift));

  // Next-state logic: phase counter, integrator, output, strobe, sticky flag.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    count_d    = (count_q == CW'(PERIOD - 1)) ? '0 : count_q + 1'b1;
    sum_d      = sum_q;
    df_d       = df_q;
    df_valid_d = 1'b0;
    sat_d      = sat_q;
    if (clear) begin
      count_d = '0;
      sum_d   = '0;
      df_d    = '0;
      sat_d   = 1'b0;
    end else if (!freeze) begin
      if (phase_a) begin
        sum_d = sum_res[DW-1:0];
        if (sum_res[DW]) sat_d = 1'b1;
      end
      if (phase_b) begin
        df_d       = df_res[DW-1:0];
        df_valid_d = 1'b1;
        if (df_res[DW]) sat_d = 1'b1;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: non-blocking assignments so all flops update from pre-edge values.
    if (!rst) begin
      count_q    <= '0;
      sum_q      <= '0;
      df_q       <= '0;
      df_valid_q <= 1'b0;
      sat_q      <= 1'b0;
    end else begin
      count_q    <= count_d;
      sum_q      <= sum_d;
      df_q       <= df_d;
      df_valid_q <= df_valid_d;
      sat_q      <= sat_d;
    end
  end

  assign frequency_df = df_q;
  assign df_valid     = df_valid_q;
  assign sat          = sat_q;

`ifdef LF_LOCK_EN
  localparam int LW = $clog2(LOCK_CNT + 1);
  localparam logic [DW-1:0] THR = DW'(LOCK_THR);

  logic [LW-1:0] lock_cnt_q, lock_cnt_d;
  logic [DW-1:0] pd_mag;
  logic          pd_in_thr;

  // The most negative pd has no positive magnitude and counts as out of threshold.
  assign pd_mag    = pd[DW-1] ? -pd : pd;
  assign pd_in_thr = (pd != DF_MIN) && (pd_mag <= THR);

  // Lock counter: counts consecutive in-threshold phase B samples, saturating.
  always_comb begin
    lock_cnt_d = lock_cnt_q;
    if (clear) begin
      lock_cnt_d = '0;
    end else if (phase_b && !freeze) begin
      if (!pd_in_thr)                          lock_cnt_d = '0;
      else if (lock_cnt_q != LW'(LOCK_CNT))    lock_cnt_d = lock_cnt_q + 1'b1;
    end
  end

  // Lock counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lock_cnt_q <= '0;
    else      lock_cnt_q <= lock_cnt_d;
  end

  assign locked = (lock_cnt_q == LW'(LOCK_CNT));
`else
  // No lock detector in this build: the expression is constant 0.
  assign locked = (LOCK_THR < 0) && (LOCK_CNT < 0);
`endif

endmodule

// File: tb/tb_loop_filter_pi.sv
// Testbench for loop_filter_pi (DW=28, PERIOD=8, LOCK_THR=100, LOCK_CNT=4).
// A plain-arithmetic model runs alongside the DUT and is compared on every
// falling edge; directed scenarios add hand-computed literal expectations.
// Define LF_LOCK_EN for both bench and RTL to exercise the lock detector.
module tb_loop_filter_pi;

  localparam int     DW     = 28;
  localparam int     PERIOD = 8;
  localparam longint MAXV   = 134217727;
  localparam longint MINV   = -134217728;

  logic                 clk = 1'b0;
  logic                 rst;
  logic signed [DW-1:0] pd;
  logic [4:0]           c1_shift, c2_shift;
  logic                 freeze, clear;
  logic signed [DW-1:0] frequency_df;
  logic                 df_valid, sat, locked;

  int n_checks = 0;
  int n_fail   = 0;

  loop_filter_pi #(.DW(DW), .PERIOD(PERIOD), .SW(5), .LOCK_THR(100), .LOCK_CNT(4)) dut (
    .clk(clk), .rst(rst), .pd(pd), .c1_shift(c1_shift), .c2_shift(c2_shift),
    .freeze(freeze), .clear(clear), .frequency_df(frequency_df),
    .df_valid(df_valid), .sat(sat), .locked(locked)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int     m_phase;   // clocks since reset/clear, modulo PERIOD
  longint m_sum, m_df;
  bit     m_val, m_sat;
  int     m_lock;

  function automatic longint shr_m(input longint v, input int s);
    if (s >= DW) return 0;
    return v >>> s;           // floor division by 2^s
  endfunction

  function automatic longint clampv(input longint v);
    if (v > MAXV) return MAXV;
    if (v < MINV) return MINV;
    return v;
  endfunction

  always @(posedge clk or negedge rst) begin
    longint raw, p;
    if (!rst) begin
      m_phase = 0; m_sum = 0; m_df = 0; m_val = 0; m_sat = 0; m_lock = 0;
    end else if (clear) begin
      m_phase = 0; m_sum = 0; m_df = 0; m_val = 0; m_sat = 0; m_lock = 0;
    end else begin
      p = longint'(pd);
      m_val = 0;
      if (!freeze && m_phase == 1) begin
        raw = m_sum + shr_m(p, int'(c2_shift));
        if (clampv(raw) != raw) m_sat = 1;
        m_sum = clampv(raw);
      end
      if (!freeze && m_phase == 2) begin
        raw = m_sum + shr_m(p, int'(c1_shift));
        if (clampv(raw) != raw) m_sat = 1;
        m_df  = clampv(raw);
        m_val = 1;
        if (p != MINV && (p < 0 ? -p : p) <= 100) m_lock = (m_lock < 4) ? m_lock + 1 : 4;
        else m_lock = 0;
      end
      m_phase = (m_phase + 1) % PERIOD;
    end
  end

  function automatic bit exp_locked();
`ifdef LF_LOCK_EN
    return m_lock == 4;
`else
    return 1'b0;
`endif
  endfunction

  // Continuous compare against the model on every falling edge.
  always @(negedge clk) begin
    check("model_df",     longint'(frequency_df), m_df);
    check("model_valid",  longint'(df_valid),     longint'(m_val));
    check("model_sat",    longint'(sat),          longint'(m_sat));
    check("model_locked", longint'(locked),       longint'(exp_locked()));
  end

  // Waits (bounded) for the next df_valid; n = falling edges waited.
  task automatic wait_valid(input string name, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!df_valid && n < 40);
    if (!df_valid) check({name, "_timeout"}, 0, 1);
  endtask

  task automatic wait_phase(input int ph);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (m_phase != ph && k < 20);
    if (m_phase != ph) check("phase_timeout", 0, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, bad;
    rst = 1'b0; pd = 28'sd256; c1_shift = 5'd3; c2_shift = 5'd8;
    freeze = 1'b0; clear = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_df", longint'(frequency_df), 0);
    check("rst_valid", longint'(df_valid), 0);
    check("rst_sat", longint'(sat), 0);
    check("rst_locked", longint'(locked), 0);

    // Basic: constant pd=256, c1=3, c2=8 -> Nth update = 32+N
    @(negedge clk);
    rst = 1'b1;
    wait_valid("basic1", n);
    check("basic_first_latency", n, 3);
    check("basic_df1", longint'(frequency_df), 33);
    for (int k = 2; k <= 5; k++) begin
      wait_valid("basic", n);
      check("basic_period", n, 8);
      check("basic_dfN", longint'(frequency_df), 32 + k);
    end

    // Freeze for 24 clocks: output holds 37, no strobes; then resumes with 38
    freeze = 1'b1;
    bad = 0;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      if (df_valid || frequency_df != 28'sd37) bad++;
    end
    check("freeze_hold_violations", bad, 0);
    freeze = 1'b0;
    wait_valid("unfreeze", n);
    check("unfreeze_period", n, 8);
    check("unfreeze_df", longint'(frequency_df), 38);

    // Positive saturation from a cleared state
    clear = 1'b1; pd = 28'sd134217727; c1_shift = 5'd0; c2_shift = 5'd0;
    @(negedge clk);
    clear = 1'b0;
    wait_valid("sat1", n);
    check("sat1_df", longint'(frequency_df), MAXV);
    check("sat1_flag", longint'(sat), 1);
    wait_valid("sat2", n);
    check("sat2_df_no_wrap", longint'(frequency_df), MAXV);
    // Negative saturation: sum = MAX+MIN = -1, output clamps at MIN
    pd = -28'sd134217728;
    wait_valid("satn1", n);
    check("satn1_df", longint'(frequency_df), MINV);
    wait_valid("satn2", n);
    check("satn2_df", longint'(frequency_df), MINV);
    check("satn_flag_sticky", longint'(sat), 1);

    // Clear coincident with count==2, then negative pd with c2_shift=31
    wait_phase(2);
    clear = 1'b1; pd = -28'sd256; c1_shift = 5'd3; c2_shift = 5'd31;
    @(negedge clk);
    clear = 1'b0;
    check("clear_df", longint'(frequency_df), 0);
    check("clear_sat", longint'(sat), 0);
    check("clear_valid", longint'(df_valid), 0);
    wait_valid("clear_lat", n);
    check("clear_latency", n, 3);
    check("neg_df1", longint'(frequency_df), -32);
    for (int k = 0; k < 2; k++) begin
      wait_valid("neg", n);
      check("neg_dfN", longint'(frequency_df), -32);
    end

    // Asynchronous reset between edges at count==5
    wait_phase(5);
    #2 rst = 1'b0;
    #1;
    check("async_rst_df", longint'(frequency_df), 0);
    check("async_rst_valid", longint'(df_valid), 0);
    check("async_rst_sat", longint'(sat), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    wait_valid("rst_release", n);
    check("rst_release_latency", n, 3);
    check("rst_release_df", longint'(frequency_df), -32);

    // Lock: pd=50 locks on 4th update, pd=101 drops it, pd=-100 (boundary) relocks
    @(negedge clk);
    clear = 1'b1; pd = 28'sd50; c1_shift = 5'd3; c2_shift = 5'd8;
    @(negedge clk);
    clear = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      wait_valid("lock", n);
`ifdef LF_LOCK_EN
      check("lock_rise", longint'(locked), (k == 4) ? 1 : 0);
`else
      check("lock_absent", longint'(locked), 0);
`endif
    end
    pd = 28'sd101;
    wait_valid("lock_drop", n);
    check("lock_drop", longint'(locked), 0);
    pd = -28'sd100;
    for (int k = 1; k <= 4; k++) begin
      wait_valid("relock", n);
`ifdef LF_LOCK_EN
      check("relock", longint'(locked), (k == 4) ? 1 : 0);
`else
      check("relock_absent", longint'(locked), 0);
`endif
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
